// File: rtl/gpu_pkg.sv
// Shared GPU-side constants and the column buffer swap-state encoding.
package gpu_pkg;

    localparam int unsigned COLUMN_COUNT   = 320;
    localparam int unsigned COLUMN_INDEX_W = 9;
    localparam logic [15:0] FAR_DISTANCE   = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVsync,
        StWaitAck,
        StClear
    } swap_state_e;

endpackage

// File: rtl/column_buffer_if.sv
// CPU write / swap handshake and GPU read bus of the column buffer.
interface column_buffer_if
    import gpu_pkg::*;
#(
    parameter int unsigned INDEX_W = COLUMN_INDEX_W
);
    logic               wr_valid;
    logic               wr_ready;
    logic [INDEX_W-1:0] wr_index;
    logic [15:0]        wr_distance;
    logic [15:0]        wr_texture;
    logic               wr_err;
    logic               swap_req;
    logic               swap_done;
    logic               v_sync;
    logic               buffer_select;
    logic               reading_buffer;
    logic [INDEX_W-1:0] reading_index;
    logic [15:0]        distance;
    logic [15:0]        texture;

    modport master (
        output wr_valid, wr_index, wr_distance, wr_texture, swap_req,
        output v_sync, reading_buffer, reading_index,
        input  wr_ready, wr_err, swap_done, buffer_select, distance, texture
    );

    modport slave (
        input  wr_valid, wr_index, wr_distance, wr_texture, swap_req,
        input  v_sync, reading_buffer, reading_index,
        output wr_ready, wr_err, swap_done, buffer_select, distance, texture
    );
endinterface

// File: rtl/column_bank.sv
// One bank of column storage: simple dual-port RAM with a registered read port.
module column_bank
    import gpu_pkg::*;
#(
    parameter int unsigned COLUMNS = COLUMN_COUNT,
    parameter int unsigned INDEX_W = COLUMN_INDEX_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic [INDEX_W-1:0] raddr,
    output logic [31:0]        rdata
);
    logic [31:0] mem [COLUMNS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/column_buffer.sv
// Double-buffered column store with a vsync-aligned bank swap handshake.
// Optional COLUMN_BUFFER_CLEAR_EN: clear the new back bank to far-wall after every swap.
module column_buffer
    import gpu_pkg::*;
#(
    parameter int unsigned COLUMNS = COLUMN_COUNT,
    parameter int unsigned INDEX_W = COLUMN_INDEX_W
) (
    input  logic            clk,
    input  logic            clr,
    column_buffer_if.slave  bus
);
    swap_state_e        state_q, state_d;
    logic               sel_q, sel_d;
    logic               done_q, done_d;
    logic               err_q;
    logic               rd_oob_q, rd_bank_q;
    logic               wr_accept, wr_in_range, wr_en;
    logic [INDEX_W-1:0] waddr;
    logic [31:0]        wdata, rdata0, rdata1, rd_word;
`ifdef COLUMN_BUFFER_CLEAR_EN
    logic [INDEX_W-1:0] cnt_q, cnt_d;
`endif

    assign wr_accept   = bus.wr_valid && (state_q == StIdle);
    assign wr_in_range = 32'(bus.wr_index) < COLUMNS;

    // Write port: CPU data, or far-wall fill while clearing; always lands in the back bank.
    always_comb begin
        wr_en = wr_accept && wr_in_range;
        waddr = bus.wr_index;
        wdata = {bus.wr_distance, bus.wr_texture};
`ifdef COLUMN_BUFFER_CLEAR_EN
        if (state_q == StClear) begin
            wr_en = 1'b1;
            waddr = cnt_q;
            wdata = {FAR_DISTANCE, 16'h0000};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
`ifdef COLUMN_BUFFER_CLEAR_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.swap_req) state_d = StWaitVsync;
            end
            StWaitVsync: begin
                if (!bus.v_sync) begin
                    sel_d   = ~sel_q;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (bus.reading_buffer == sel_q) begin
`ifdef COLUMN_BUFFER_CLEAR_EN
                    cnt_d   = '0;
                    state_d = StClear;
`else
                    done_d  = 1'b1;
                    state_d = StIdle;
`endif
                end
            end
`ifdef COLUMN_BUFFER_CLEAR_EN
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INDEX_W'(COLUMNS - 1)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_oob_q  <= 1'b1;
            rd_bank_q <= 1'b0;
`ifdef COLUMN_BUFFER_CLEAR_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
            if (wr_accept && !wr_in_range) err_q <= 1'b1;
            rd_oob_q  <= !(32'(bus.reading_index) < COLUMNS);
            rd_bank_q <= bus.reading_buffer;
`ifdef COLUMN_BUFFER_CLEAR_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    column_bank #(
        .COLUMNS (COLUMNS),
        .INDEX_W (INDEX_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_en && sel_q),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.reading_index),
        .rdata (rdata0)
    );

    column_bank #(
        .COLUMNS (COLUMNS),
        .INDEX_W (INDEX_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_en && !sel_q),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.reading_index),
        .rdata (rdata1)
    );

    // The out-of-range flag is reset high so the outputs read as far wall straight out of clr.
    assign rd_word           = rd_bank_q ? rdata1 : rdata0;
    assign bus.distance      = rd_oob_q ? FAR_DISTANCE : rd_word[31:16];
    assign bus.texture       = rd_oob_q ? 16'h0000 : rd_word[15:0];
    assign bus.wr_ready      = (state_q == StIdle);
    assign bus.wr_err        = err_q;
    assign bus.swap_done     = done_q;
    assign bus.buffer_select = sel_q;
endmodule

// File: tb/tb_column_buffer.sv
// Directed bench for column_buffer: reference bank model plus a read scoreboard.
module tb_column_buffer;
    import gpu_pkg::*;

`ifdef COLUMN_BUFFER_CLEAR_EN
    localparam int CLEAR_CYC = COLUMN_COUNT;
`else
    localparam int CLEAR_CYC = 0;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] t;
    } rd_t;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    rd_t  sb[$];
    logic [31:0] model [2][COLUMN_COUNT];
    logic model_sel;
    int   n, rdy;

    always #5 clk = ~clk;

    column_buffer_if #(.INDEX_W(COLUMN_INDEX_W)) bus ();

    column_buffer #(
        .COLUMNS (COLUMN_COUNT),
        .INDEX_W (COLUMN_INDEX_W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [15:0] d, input logic [15:0] t);
        chk($sformatf("wr_ready@%0d", idx), 32'(bus.wr_ready), 32'd1);
        bus.wr_valid    = 1'b1;
        bus.wr_index    = COLUMN_INDEX_W'(idx);
        bus.wr_distance = d;
        bus.wr_texture  = t;
        tick();
        bus.wr_valid = 1'b0;
        if (idx < COLUMN_COUNT) model[!model_sel][idx] = {d, t};
    endtask

    task automatic rd(input logic b, input int idx);
        rd_t e;
        bus.reading_buffer = b;
        bus.reading_index  = COLUMN_INDEX_W'(idx);
        if (idx >= COLUMN_COUNT) e = {FAR_DISTANCE, 16'h0000};
        else                     e = model[b][idx];
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        chk($sformatf("rd_dist b%0d i%0d", b, idx), 32'(bus.distance), 32'(e.d));
        chk($sformatf("rd_tex b%0d i%0d", b, idx), 32'(bus.texture), 32'(e.t));
    endtask

    // Ticks until swap_done is seen (bounded); counts cycles in which wr_ready was wrongly high.
    task automatic wait_done(output int cyc, output int ready_cnt);
        cyc = 0;
        ready_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cyc++;
            if (bus.swap_done) break;
            if (bus.wr_ready) ready_cnt++;
        end
        if (bus.swap_done) begin
            model_sel = !model_sel;
            if (CLEAR_CYC > 0) begin
                for (int j = 0; j < COLUMN_COUNT; j++) model[!model_sel][j] = {FAR_DISTANCE, 16'h0};
            end
        end
    endtask

    initial begin
        bus.wr_valid       = 1'b0;
        bus.wr_index       = '0;
        bus.wr_distance    = '0;
        bus.wr_texture     = '0;
        bus.swap_req       = 1'b0;
        bus.v_sync         = 1'b1;
        bus.reading_buffer = 1'b0;
        bus.reading_index  = '0;
        model_sel          = 1'b0;
        clr                = 1'b1;
        tick();
        tick();
        clr = 1'b0;

        chk("rst_sel", 32'(bus.buffer_select), 32'd0);
        chk("rst_dist", 32'(bus.distance), 32'hFFFF);
        chk("rst_tex", 32'(bus.texture), 32'h0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_err", 32'(bus.wr_err), 32'd0);
        chk("rst_done", 32'(bus.swap_done), 32'd0);

        wr(5, 16'h0123, 16'h002A);
        wr(0, 16'h1111, 16'h0001);
        wr(319, 16'h2222, 16'h003F);
        bus.swap_req = 1'b1;
        wr(7, 16'h0777, 16'h0007);
        bus.swap_req = 1'b0;

        // Writes offered while waiting for vsync must be refused.
        bus.wr_valid    = 1'b1;
        bus.wr_index    = COLUMN_INDEX_W'(5);
        bus.wr_distance = 16'hDEAD;
        bus.wr_texture  = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wv_ready", 32'(bus.wr_ready), 32'd0);
            chk("wv_sel", 32'(bus.buffer_select), 32'd0);
        end
        bus.wr_valid = 1'b0;

        bus.v_sync = 1'b0;
        tick();
        chk("toggle_sel", 32'(bus.buffer_select), 32'd1);
        bus.v_sync = 1'b1;
        tick();
        chk("ack_wait_done", 32'(bus.swap_done), 32'd0);
        chk("ack_wait_ready", 32'(bus.wr_ready), 32'd0);

        bus.reading_buffer = 1'b1;
        wait_done(n, rdy);
        chk("swap1_latency", 32'(n), 32'(1 + CLEAR_CYC));
        chk("swap1_ready_low", 32'(rdy), 32'd0);
        chk("swap1_ready_after", 32'(bus.wr_ready), 32'd1);
        tick();
        chk("swap1_done_pulse", 32'(bus.swap_done), 32'd0);

        rd(1'b1, 5);
        rd(1'b1, 0);
        rd(1'b1, 319);
        rd(1'b1, 7);
        rd(1'b1, 320);
        rd(1'b1, 400);

        wr(5, 16'h0AAA, 16'h0015);
        rd(1'b1, 5);
        rd(1'b0, 5);

        wr(320, 16'hBAD0, 16'hBAD1);
        chk("err_set", 32'(bus.wr_err), 32'd1);
        wr(6, 16'h0666, 16'h0006);
        tick();
        chk("err_sticky", 32'(bus.wr_err), 32'd1);
        rd(1'b0, 5);

        // Fastest swap: vsync already low and the GPU follows immediately.
        bus.reading_buffer = 1'b0;
        bus.v_sync         = 1'b0;
        bus.swap_req       = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        chk("fast_sel_hold", 32'(bus.buffer_select), 32'd1);
        chk("fast_ready", 32'(bus.wr_ready), 32'd0);
        wait_done(n, rdy);
        chk("fast_latency", 32'(n), 32'(2 + CLEAR_CYC));
        chk("fast_ready_low", 32'(rdy), 32'd0);
        chk("fast_sel", 32'(bus.buffer_select), 32'd0);

        // Abort in WAIT_ACK: GPU never follows, clr lands mid-swap.
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        chk("abort_sel_toggled", 32'(bus.buffer_select), 32'd1);
        tick();
        chk("abort_wait_done", 32'(bus.swap_done), 32'd0);
        chk("abort_wait_ready", 32'(bus.wr_ready), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.v_sync = 1'b1;
        chk("abort_sel", 32'(bus.buffer_select), 32'd0);
        chk("abort_ready", 32'(bus.wr_ready), 32'd1);
        chk("abort_err", 32'(bus.wr_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done", 32'(bus.swap_done), 32'd0);
            tick();
        end

        rd(1'b1, 5);
        rd(1'b0, 5);
        rd(1'b0, 6);
        wr(9, 16'h0999, 16'h0009);
        rd(1'b1, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/column_buffer.md
# column_buffer

Double-buffered column store between the CPU raycaster and the GPU scan-out. The CPU writes one `{distance, texture}` pair per screen column into the back bank. The GPU reads the front bank by column index. A vsync-aligned handshake swaps the banks so the GPU never scans a half-written frame. This block is the writer/storage end of the GPU's `buffer_select` / `reading_buffer` / `reading_index` / `distance` / `texture` interface.

## Interface
Parameters:
- `COLUMNS`, 320, number of screen columns per bank.
- `INDEX_W`, 9, index width; must satisfy 2^INDEX_W >= COLUMNS.

Ports:
- `clk`  in  1  system clock; the only clock.
- `clr`  in  1  reset; synchronous, active-high.
- `wr_valid`  in  1  CPU write request.
- `wr_ready`  out  1  block can accept a write this cycle.
- `wr_index`  in  INDEX_W  target column.
- `wr_distance`  in  16  wall distance.
- `wr_texture`  in  16  texture word; the GPU uses bits [5:0] as the u coordinate.
- `wr_err`  out  1  sticky flag: an out-of-range write was dropped.
- `swap_req`  in  1  CPU one-cycle pulse: frame complete, swap at next vsync.
- `swap_done`  out  1  one-cycle pulse: swap finished; the back bank is writable again.
- `v_sync`  in  1  GPU vertical sync, active-low.
- `buffer_select`  out  1  bank the GPU should display.
- `reading_buffer`  in  1  bank the GPU has actually latched.
- `reading_index`  in  INDEX_W  GPU column read address.
- `distance`  out  16  read data, distance.
- `texture`  out  16  read data, texture.

## Operation
- Storage: two banks of `COLUMNS` x 32 bits, `{distance, texture}`.
- Writes always target bank `~buffer_select`.
- Reads always come from bank `reading_buffer`, not from `buffer_select`.
- Write handshake:
  - A write is accepted when `wr_valid && wr_ready`.
  - `wr_ready` = 1 only in IDLE.
  - If `wr_index >= COLUMNS`, the write is accepted but no RAM write occurs, and `wr_err` is set. `wr_err` clears only on `clr`.
- Read path:
  - `reading_index >= COLUMNS`: outputs `distance` = 16'hFFFF (far wall) and `texture` = 0.
  - This covers GPU index underflow during horizontal blanking.
- Swap FSM:
  - IDLE: `swap_req` -> WAIT_VSYNC. A `wr_valid` in the same cycle as `swap_req` is accepted first.
  - WAIT_VSYNC: no writes. When `v_sync` == 0, toggle `buffer_select` -> WAIT_ACK.
  - WAIT_ACK: no writes. When `reading_buffer == buffer_select`, pulse `swap_done` -> IDLE (or CLEAR, see Configuration).
  - `swap_req` in any state other than IDLE is ignored (not queued).
  - If `v_sync` is already low when WAIT_VSYNC is entered, the toggle happens that same cycle. Consecutive frames may therefore swap within one vsync period.

## Timing
- Reset values: `buffer_select` = 0, `distance` = 16'hFFFF, `texture` = 0, `swap_done` = 0, `wr_err` = 0, state = IDLE, so `wr_ready` = 1 from the first cycle after `clr` deasserts.
- `clr` mid-swap aborts the swap:
  - `buffer_select` returns to 0.
  - No `swap_done` is produced.
  - RAM contents are kept; there is no reset clear.
- Write: the RAM is updated at the accepting edge and is readable through the read path on the next cycle.
- Read latency: exactly 1 clk from `reading_index` / `reading_buffer` to registered `distance` / `texture`. The GPU samples every 4 clk, so this is within budget.
- `buffer_select` changes at the edge after `v_sync` is sampled low.
- `swap_done` is asserted for 1 clk, on the cycle after the ack match is sampled.
- Minimum swap duration: 2 clk from `swap_req` to `swap_done`, when `v_sync` is low and the ack is immediate.

## Configuration
- `COLUMN_BUFFER_CLEAR_EN` defined:
  - WAIT_ACK -> CLEAR instead of IDLE.
  - CLEAR writes {16'hFFFF, 16'h0000} to indices 0..COLUMNS-1 of the new back bank, one per clk.
  - `wr_ready` = 0 throughout CLEAR.
  - `swap_done` pulses in the cycle after the index COLUMNS-1 write, then -> IDLE.
- `COLUMN_BUFFER_CLEAR_EN` undefined: there is no CLEAR state, and the back bank keeps the frame-before-last data.

## Structure
- Shared `gpu_pkg` holds:
  - `COLUMN_COUNT` = 320
  - `COLUMN_INDEX_W` = 9
  - `FAR_DISTANCE` = 16'hFFFF
  - the swap-state enum (IDLE, WAIT_VSYNC, WAIT_ACK, CLEAR)
- One sub-module, `column_bank`: simple dual-port RAM, `COLUMNS` x 32, one write port, one registered read port. Instantiate it twice.
- The top level holds the FSM, the range checks, the bank muxing and the clear counter.

## Test plan
- Reset: assert `clr` for 2 clk -> `buffer_select` = 0, `distance` = FFFF, `texture` = 0, `wr_ready` = 1, `wr_err` = 0.
- Write then swap:
  - Write index 5, distance 0x0123, texture 0x002A, then pulse `swap_req`.
  - Hold `v_sync` = 1 for 10 clk -> `wr_ready` = 0 and `buffer_select` = 0 throughout.
  - Drive `v_sync` = 0 -> `buffer_select` = 1 on the next clk.
  - Drive `reading_buffer` = 1 -> `swap_done` pulses once.
  - `reading_index` = 5 -> 0x0123 / 0x002A one clk later.
- Bad write index: `wr_index` = 320 with `wr_valid` -> write accepted, no RAM change, `wr_err` = 1 and held until `clr`.
- Bad read index: `reading_index` = 400 -> `distance` = FFFF, `texture` = 0 one clk later.
- Reset mid-swap: `clr` in WAIT_ACK -> IDLE, `buffer_select` = 0, no `swap_done`, previously written data still readable.
- With `COLUMN_BUFFER_CLEAR_EN`: after a swap completes, `wr_ready` = 0 for 320 clk, then `swap_done` pulses. Every index of the new back bank then reads FFFF / 0 after the next swap.
